// File: rtl/psum_deskew_drain.sv
// psum_deskew_drain
//   Consumer end of the systolic array's bottom edge. The last PE row emits each
//   result row with column skew (column j arrives j cycles after column 0). This
//   block re-aligns the lanes, queues aligned rows in a small first-word-fall-
//   through FIFO and hands them downstream over valid/ready.
//
// Ports
//   clk, rst          single clock; async active-high reset
//   in_valid          column 0 of a row is on psum_in_packed this cycle
//   psum_in_packed    array_n skewed lanes, lane j at [W*j +: W]
//   out_valid         aligned row available at the FIFO head
//   out_ready         downstream accepts the head row
//   out_data_packed   aligned head row, lane j at [W*j +: W]
//   fifo_count        rows currently buffered
//   overflow          sticky: an aligned row arrived to a full FIFO and was lost

// One lane's delay line, depth >= 1 registers.
module psum_deskew_lane #(
    parameter int lane_w = 18,
    parameter int depth  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [lane_w-1:0] d,
    output logic [lane_w-1:0] q
);
    logic [depth-1:0][lane_w-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int k = 1; k < depth; k++) sr[k] <= sr[k-1];
        end
    end

    assign q = sr[depth-1];
endmodule

module psum_deskew_drain #(
    parameter int array_n         = 4,
    parameter int data_width      = 8,
    parameter int log2_array_m    = 2,
    parameter int fifo_depth      = 4,
    parameter int log2_fifo_depth = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           in_valid,
    input  logic [array_n*(2*data_width+log2_array_m)-1:0] psum_in_packed,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [array_n*(2*data_width+log2_array_m)-1:0] out_data_packed,
    output logic [log2_fifo_depth:0]                       fifo_count,
    output logic                                           overflow
);
    localparam int W      = 2*data_width + log2_array_m;
    localparam int ROW_W  = array_n * W;
    localparam int STAGES = array_n - 1;

    // ---------------- deskew ----------------
    // The valid travels the full depth; lane j only needs the remaining
    // array_n-1-j stages because it enters j cycles late.
    logic [STAGES:0]              vld_pipe;
    logic [array_n-1:0][W-1:0]    aligned;
    logic                         row_valid;

    generate
        if (STAGES > 0) begin : g_vld
            logic [STAGES-1:0] vld_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_q <= '0;
                else     vld_q <= vld_pipe[STAGES-1:0];
            end
            assign vld_pipe = {vld_q, in_valid};
        end else begin : g_vld_comb
            assign vld_pipe = in_valid;
        end
    endgenerate

    assign row_valid = vld_pipe[STAGES];

    generate
        for (genvar j = 0; j < array_n; j++) begin : g_lane
            if (j == array_n-1) begin : g_pass
                // last column arrives already aligned
                assign aligned[j] = psum_in_packed[W*j +: W];
            end else begin : g_dly
                psum_deskew_lane #(.lane_w(W), .depth(array_n-1-j)) u_lane (
                    .clk (clk),
                    .rst (rst),
                    .d   (psum_in_packed[W*j +: W]),
                    .q   (aligned[j])
                );
            end
        end
    endgenerate

    // ---------------- FIFO ----------------
    logic [ROW_W-1:0]             mem [fifo_depth];
    logic [log2_fifo_depth-1:0]   wr_ptr, rd_ptr;
    logic                         full, push, pop;

    assign full      = (fifo_count == (log2_fifo_depth+1)'(fifo_depth));
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    // a full FIFO still takes a row when the head leaves in the same cycle
    assign push      = row_valid && (!full || pop);
    assign out_data_packed = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // clearing storage keeps out_data_packed at zero after reset
            for (int i = 0; i < fifo_depth; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= aligned;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (row_valid && full && !pop) overflow <= 1'b1;
        end
    end
endmodule
